pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Pipeline control unit for the 16-bit in-order core.
- Sequences the PC register, the IF/ID pipeline register and the ID/EX pipeline register by generating their write-enables and flushes.
- Resolves three conditions: taken-branch redirects (with configurable bubble count), load-use hazards, and instruction-memory fetch stalls.
- Sits beside the fetch stage; its outputs drive the PC enable and the enable/flush inputs of IF/ID and ID/EX.

## Interface
- REG_ADDR_W, 4: register-address width (16 architectural registers, r0 hardwired to zero).
- FLUSH_CYCLES, 1: bubbles inserted per taken branch; legal range 1..3.
- PERF_W, 16: stall-counter width.

- clk  in  1  system clock, rising edge.
- reset_n  in  1  reset; one clock, reset is asynchronous and active-low.
- id_rs1  in  REG_ADDR_W  source register 1 of the instruction in ID.
- id_rs2  in  REG_ADDR_W  source register 2 of the instruction in ID.
- id_rs1_used  in  1  ID instruction reads rs1.
- id_rs2_used  in  1  ID instruction reads rs2.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rd  in  REG_ADDR_W  destination register of the EX instruction.
- ex_branch_taken  in  1  branch resolved taken in EX this cycle.
- imem_valid  in  1  instruction memory presents a valid instruction this cycle.
- pc_write_en  out  1  PC register update enable.
- ifid_write_en  out  1  IF/ID update enable.
- ifid_flush  out  1  load a NOP (16'h0000) into IF/ID; has priority over ifid_write_en.
- idex_flush  out  1  load a bubble into ID/EX.
- ctrl_state  out  2  current FSM state.
- stall_count  out  PERF_W  cycles with pc_write_en=0 (see Configuration).

## Operation
- Load-use hazard: ex_mem_read && ex_rd!=0 && ((id_rs1_used && id_rs1==ex_rd) || (id_rs2_used && id_rs2==ex_rd)).
- Event priority within any state: ex_branch_taken > load-use > fetch stall (imem_valid=0).
- States: RUN=0, WAIT=1, FLUSH=2; 3 is unreachable and recovers to RUN.
- RUN and WAIT share the same decode:
  - Branch: pc_write_en=1 (PC loads target), ifid_flush=1, idex_flush=1. Next state is FLUSH with bubble counter = FLUSH_CYCLES-1 when FLUSH_CYCLES>1; otherwise RUN.
  - Load-use: pc_write_en=0, ifid_write_en=0, idex_flush=1. Next state RUN.
  - Fetch stall: pc_write_en=0, ifid_write_en=1, ifid_flush=1. Next state WAIT.
  - Otherwise: pc_write_en=1, ifid_write_en=1, both flushes 0. Next state RUN.
- FLUSH:
  - Outputs: pc_write_en=0, ifid_write_en=1, ifid_flush=1, idex_flush=0.
  - Bubble counter decrements each cycle; go to RUN on the cycle the counter reads 1.
  - A new ex_branch_taken in FLUSH is ignored (EX holds a bubble).
- Outputs are combinational from registered state plus current inputs. State and bubble counter are registered.

## Timing
- Asserting reset_n=0 immediately (asynchronously) forces: state=RUN, bubble counter=0, stall_count=0.
- While reset_n=0, outputs are forced to pc_write_en=0, ifid_write_en=0, ifid_flush=1, idex_flush=1.
- First normal decode occurs in the first cycle with reset_n=1.
- Hazard response is zero-latency: outputs change in the same cycle as the inputs.
- State changes on the next rising edge.
- Load-use costs exactly 1 stall cycle; the load leaves EX on the following edge.
- A taken branch costs exactly FLUSH_CYCLES cycles of ifid_flush=1.
- Reset asserted mid-FLUSH aborts the remaining bubbles.
- imem_valid returning to 1 in WAIT resumes normal issue in that same cycle.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_count increments on every rising edge where reset_n=1 and pc_write_en=0.
  - Saturates at all-ones; never wraps.
- Not defined: stall_count is tied to 0 and no counter logic is built.

## Structure
- Package pipeline_ctrl_pkg holds:
  - ctrl_state_e enum (RUN, WAIT, FLUSH);
  - default REG_ADDR_W;
  - NOP encoding constant 16'h0000.
- Sub-module load_use_detect: purely combinational; implements the hazard equation and outputs a single hazard bit.

## Test plan
- Reset: reset_n=0 mid-FLUSH with FLUSH_CYCLES=3 -> state=RUN, flush outputs=1, pc_write_en=0, stall_count=0, all immediately.
- Load-use: ex_mem_read=1, ex_rd=3, id_rs2=3, id_rs2_used=1 -> one cycle with pc_write_en=0, ifid_write_en=0, idex_flush=1. Same stimulus with ex_rd=0 -> no stall.
- Branch, FLUSH_CYCLES=3: ex_branch_taken pulse -> 1 cycle pc_write_en=1 with both flushes, then 2 FLUSH cycles with ifid_flush=1, then RUN. A second branch pulse during FLUSH is ignored.
- Priority: branch and load-use asserted in the same cycle -> branch outputs (pc_write_en=1, idex_flush=1).
- Fetch stall: imem_valid low for 4 cycles -> 4 cycles of pc_write_en=0 and ifid_flush=1; normal issue resumes in the cycle imem_valid=1.
- Counter (macro defined, PERF_W=4): 20 stall cycles -> stall_count=15 (saturated). Macro undefined -> stall_count=0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Used by pipeline_hazard_ctrl and load_use_detect.
package pipeline_ctrl_pkg;

    localparam int DEF_REG_ADDR_W = 4;
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        FLUSH = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: the ID instruction reads the register
// that the load currently in EX will write (r0 never creates a hazard).
module load_use_detect
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  hazard
);

    logic rs1_match_s;
    logic rs2_match_s;

    assign rs1_match_s = id_rs1_used && (id_rs1 == ex_rd);
    assign rs2_match_s = id_rs2_used && (id_rs2 == ex_rd);
    assign hazard      = ex_mem_read && (ex_rd != {REG_ADDR_W{1'b0}})
                         && (rs1_match_s || rs2_match_s);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline control for PC, IF/ID and ID/EX: branch flush, load-use and fetch stalls.
// Optional saturating stall counter enabled by defining HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W   = DEF_REG_ADDR_W,
    parameter int FLUSH_CYCLES = 1,
    parameter int PERF_W       = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_branch_taken,
    input  logic                  imem_valid,
    output logic                  pc_write_en,
    output logic                  ifid_write_en,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic [1:0]            ctrl_state,
    output logic [PERF_W-1:0]     stall_count
);

    localparam logic [1:0] BUBBLE_INIT = 2'(FLUSH_CYCLES - 1);

    ctrl_state_e state_r;
    ctrl_state_e state_nxt_s;
    logic [1:0]  bubble_r;
    logic [1:0]  bubble_nxt_s;
    logic        hazard_s;

    load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .hazard      (hazard_s)
    );

    // State and bubble counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= RUN;
            bubble_r <= 2'd0;
        end else begin
            state_r  <= state_nxt_s;
            bubble_r <= bubble_nxt_s;
        end
    end

    // Next-state and enable/flush decode; reset forces the pipeline into a flushed hold
    always_comb begin
        state_nxt_s   = RUN;
        bubble_nxt_s  = 2'd0;
        pc_write_en   = 1'b0;
        ifid_write_en = 1'b0;
        ifid_flush    = 1'b1;
        idex_flush    = 1'b1;
        if (!reset_n) begin
            state_nxt_s = RUN;
        end else begin
            case (state_r)
                RUN, WAIT: begin
                    if (ex_branch_taken) begin
                        pc_write_en   = 1'b1;
                        ifid_write_en = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_nxt_s  = FLUSH;
                            bubble_nxt_s = BUBBLE_INIT;
                        end else begin
                            state_nxt_s = RUN;
                        end
                    end else if (hazard_s) begin
                        ifid_flush  = 1'b0;
                        state_nxt_s = RUN;
                    end else if (!imem_valid) begin
                        ifid_write_en = 1'b1;
                        idex_flush    = 1'b0;
                        state_nxt_s   = WAIT;
                    end else begin
                        pc_write_en   = 1'b1;
                        ifid_write_en = 1'b1;
                        ifid_flush    = 1'b0;
                        idex_flush    = 1'b0;
                        state_nxt_s   = RUN;
                    end
                end
                // Branches arriving here are ignored: EX holds a bubble
                FLUSH: begin
                    ifid_write_en = 1'b1;
                    idex_flush    = 1'b0;
                    if (bubble_r <= 2'd1) begin
                        state_nxt_s = RUN;
                    end else begin
                        state_nxt_s  = FLUSH;
                        bubble_nxt_s = bubble_r - 2'd1;
                    end
                end
                default: begin
                    state_nxt_s = RUN;
                end
            endcase
        end
    end

    assign ctrl_state = state_r;

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cnt_r;

    // Saturating count of cycles in which the PC is held
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_r <= {PERF_W{1'b0}};
        end else if (!pc_write_en && (stall_cnt_r != {PERF_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + PERF_W'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_count = stall_cnt_r;
`else
    assign stall_count = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (FLUSH_CYCLES=3, PERF_W=4) with
// a behavioural reference model; honours HAZARD_PERF_CNT_EN when defined.
module tb_pipeline_hazard_ctrl;

    localparam int AW = 4;
    localparam int FC = 3;
    localparam int PW = 4;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] id_rs1, id_rs2, ex_rd;
    logic          id_rs1_used, id_rs2_used, ex_mem_read, ex_branch_taken, imem_valid;
    logic          pc_write_en, ifid_write_en, ifid_flush, idex_flush;
    logic [1:0]    ctrl_state;
    logic [PW-1:0] stall_count;

    int checks = 0;
    int errors = 0;

    // Reference model state: mode 0=run,1=wait,2=flush; flush_left = flush cycles still to come
    int m_mode = 0;
    int m_flush_left = 0;
    int m_cnt = 0;

    pipeline_hazard_ctrl #(
        .REG_ADDR_W   (AW),
        .FLUSH_CYCLES (FC),
        .PERF_W       (PW)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rs1_used     (id_rs1_used),
        .id_rs2_used     (id_rs2_used),
        .ex_mem_read     (ex_mem_read),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .imem_valid      (imem_valid),
        .pc_write_en     (pc_write_en),
        .ifid_write_en   (ifid_write_en),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .ctrl_state      (ctrl_state),
        .stall_count     (stall_count)
    );

    always #5 clk = ~clk;

    // Expected {pc_write_en, ifid_write_en, ifid_flush, idex_flush, ctrl_state}
    function automatic logic [5:0] exp_out();
        logic lu;
        logic [1:0] st;
        st = 2'(m_mode);
        lu = ex_mem_read && (ex_rd != 4'd0) &&
             ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
        if (!reset_n)              return {4'b0011, 2'd0};
        else if (m_mode == 2)      return {4'b0110, st};
        else if (ex_branch_taken)  return {4'b1111, st};
        else if (lu)               return {4'b0001, st};
        else if (!imem_valid)      return {4'b0110, st};
        else                       return {4'b1100, st};
    endfunction

    function automatic logic [5:0] dut_out();
        return {pc_write_en, ifid_write_en, ifid_flush, idex_flush, ctrl_state};
    endfunction

    // Advance one clock: update the model with the inputs present at the edge
    task automatic cycle();
        logic [5:0] e;
        @(posedge clk);
        e = exp_out();
        if (!reset_n) begin
            m_mode = 0; m_flush_left = 0; m_cnt = 0;
        end else begin
            if (CNT_EN && !e[5] && m_cnt < (1 << PW) - 1) m_cnt++;
            if (m_mode == 2) begin
                m_flush_left--;
                if (m_flush_left == 0) m_mode = 0;
            end else if (e == {4'b1111, 2'(m_mode)}) begin
                if (FC > 1) begin m_mode = 2; m_flush_left = FC - 1; end
                else m_mode = 0;
            end else if (e[5:2] == 4'b0001) m_mode = 0;
            else if (e[5:2] == 4'b0110)    m_mode = 1;
            else                           m_mode = 0;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        id_rs1 = 4'd0; id_rs2 = 4'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        ex_mem_read = 1'b0; ex_rd = 4'd0; ex_branch_taken = 1'b0; imem_valid = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        #1;
        checks++;
        if (dut_out() !== exp_out() || stall_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_initial got=%b/%0d want=%b/0", dut_out(), stall_count, exp_out());
        end
        cycle();
        reset_n = 1'b1;
        // Branch, then assert reset asynchronously in the middle of a FLUSH cycle
        ex_branch_taken = 1'b1;
        cycle();
        ex_branch_taken = 1'b0;
        imem_valid = 1'b0;
        #2;
        checks++;
        if (ctrl_state !== 2'd2) begin
            errors++;
            $display("FAIL reset_pre_flush state got=%0d want=2", ctrl_state);
        end
        reset_n = 1'b0;
        m_mode = 0; m_flush_left = 0; m_cnt = 0;
        #1;
        checks++;
        if (dut_out() !== 6'b001100 || stall_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid_flush got=%b/%0d want=001100/0", dut_out(), stall_count);
        end
        cycle();
        reset_n = 1'b1;
        imem_valid = 1'b1;
        #1;
        checks++;
        if (dut_out() !== exp_out() || dut_out() !== 6'b110000) begin
            errors++;
            $display("FAIL reset_first_decode got=%b want=110000", dut_out());
        end
        cycle();
    endtask

    task automatic test_load_use();
        for (int k = 0; k < 2; k++) begin
            idle_inputs();
            ex_mem_read = 1'b1; ex_rd = (k == 0) ? 4'd3 : 4'd0;
            id_rs2 = ex_rd; id_rs2_used = 1'b1;
            #1;
            checks++;
            if (dut_out() !== exp_out() || dut_out()[5:2] !== ((k == 0) ? 4'b0001 : 4'b1100)) begin
                errors++;
                $display("FAIL load_use_%0d got=%b want=%b", k, dut_out(), exp_out());
            end
            cycle();
            // Load has left EX: normal issue
            idle_inputs();
            #1;
            checks++;
            if (dut_out() !== exp_out()) begin
                errors++;
                $display("FAIL load_use_after_%0d got=%b want=%b", k, dut_out(), exp_out());
            end
            cycle();
        end
    endtask

    task automatic test_branch();
        logic [5:0] want [4] = '{6'b111100, 6'b011010, 6'b011010, 6'b110000};
        idle_inputs();
        for (int c = 0; c < 4; c++) begin
            ex_branch_taken = (c <= 1);   // second pulse lands inside FLUSH
            #1;
            checks++;
            if (dut_out() !== exp_out() || dut_out() !== want[c]) begin
                errors++;
                $display("FAIL branch_c%0d got=%b want=%b", c, dut_out(), want[c]);
            end
            cycle();
        end
        idle_inputs();
    endtask

    task automatic test_priority();
        idle_inputs();
        ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 4'd5;
        id_rs1 = 4'd5; id_rs1_used = 1'b1; imem_valid = 1'b0;
        #1;
        checks++;
        if (dut_out() !== exp_out() || pc_write_en !== 1'b1 || idex_flush !== 1'b1) begin
            errors++;
            $display("FAIL priority got=%b want=%b", dut_out(), exp_out());
        end
        idle_inputs();
        for (int c = 0; c < 3; c++) cycle();
    endtask

    task automatic test_fetch_stall();
        idle_inputs();
        for (int c = 0; c < 5; c++) begin
            imem_valid = (c == 4);
            #1;
            checks++;
            if (dut_out() !== exp_out() || dut_out()[5:2] !== ((c == 4) ? 4'b1100 : 4'b0110)) begin
                errors++;
                $display("FAIL fetch_stall_c%0d got=%b want=%b", c, dut_out(), exp_out());
            end
            cycle();
        end
    endtask

    task automatic test_counter();
        reset_n = 1'b0;
        idle_inputs();
        cycle();
        reset_n = 1'b1;
        imem_valid = 1'b0;
        for (int c = 0; c < 20; c++) cycle();
        imem_valid = 1'b1;
        #1;
        checks++;
        if (stall_count !== 4'(m_cnt) || stall_count !== (CNT_EN ? 4'd15 : 4'd0)) begin
            errors++;
            $display("FAIL counter_sat got=%0d want=%0d", stall_count, m_cnt);
        end
        cycle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            reset_n         = ($urandom_range(0, 99) != 0);
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            ex_mem_read     = $urandom_range(0, 1);
            ex_rd           = 4'($urandom_range(0, 3));
            id_rs1          = 4'($urandom_range(0, 3));
            id_rs2          = 4'($urandom_range(0, 3));
            id_rs1_used     = $urandom_range(0, 1);
            id_rs2_used     = $urandom_range(0, 1);
            imem_valid      = ($urandom_range(0, 3) != 0);
            #1;
            if (!reset_n) begin
                m_mode = 0; m_flush_left = 0; m_cnt = 0;
            end
            checks++;
            if (dut_out() !== exp_out() || stall_count !== 4'(m_cnt)) begin
                errors++;
                $display("FAIL random_c%0d got=%b/%0d want=%b/%0d", c, dut_out(), stall_count,
                         exp_out(), m_cnt);
            end
            cycle();
        end
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_priority();
        test_fetch_stall();
        test_counter();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
